// File: rtl/mod_counter_part_rtl.sv
// Modulo-MODULUS up/down counter: control FSM (RUN/HALT) plus count datapath.
// Latency: count, tc and done are registered and update on the edge that samples the inputs.
// Backpressure: none; one step is taken per enabled edge, load has priority over step.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (count=0, tc=0, done=0, FSM=RUN)
//   enable    step enable, one step per enabled edge
//   up_dn     direction, 1 = increment, 0 = decrement
//   load      synchronous load of data_in (clamped to MODULUS-1)
//   data_in   load value
//   one_shot  1 = halt at terminal value, 0 = wrap
//   count     current count
//   tc        one-cycle terminal-count pulse
//   done      one-shot complete level
//
// Build option: define MOD_COUNTER_ONE_SHOT_EN to implement the HALT state and
// one-shot behaviour. Without it one_shot is ignored, the counter always wraps
// and done stays 0.

module mod_counter_part_rtl #(
    parameter int size    = 4,
    parameter int MODULUS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            up_dn,
    input  logic            load,
    input  logic [size-1:0] data_in,
    input  logic            one_shot,
    output logic [size-1:0] count,
    output logic            tc,
    output logic            done
);

    localparam logic [size-1:0] MAX_VAL = size'(MODULUS - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [size-1:0] count_q, count_d;
    logic            tc_q, tc_d;

    logic            one_shot_eff;
    logic [size-1:0] term_val;
    logic            at_term;
    logic [size-1:0] load_val;

`ifdef MOD_COUNTER_ONE_SHOT_EN
    assign one_shot_eff = one_shot;
`else
    // Forcing the mode off keeps the FSM permanently in RUN.
    logic unused_one_shot;
    assign unused_one_shot = one_shot;
    assign one_shot_eff    = 1'b0;
`endif

    // Terminal value follows the direction sampled on this same edge.
    assign term_val = up_dn ? MAX_VAL : '0;
    assign at_term  = (count_q == term_val);
    assign load_val = (data_in > MAX_VAL) ? MAX_VAL : data_in;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;

        if (load) begin
            count_d = load_val;
            state_d = ST_RUN;
        end else if (enable && (state_q == ST_RUN)) begin
            if (!at_term) begin
                count_d = up_dn ? (count_q + 1'b1) : (count_q - 1'b1);
            end else if (one_shot_eff) begin
                // Terminal step in one-shot: hold at T and freeze.
                state_d = ST_HALT;
                tc_d    = 1'b1;
            end else begin
                count_d = up_dn ? '0 : MAX_VAL;
                tc_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    // HALT is a registered state, so done is a registered level.
    assign done  = (state_q == ST_HALT);

endmodule

// File: tb/tb_mod_counter_part_rtl.sv
module tb_mod_counter_part_rtl;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         up_dn;
    logic         load;
    logic [W-1:0] data_in;
    logic         one_shot;
    logic [W-1:0] count;
    logic         tc;
    logic         done;

    mod_counter_part_rtl #(.size(W), .MODULUS(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .up_dn    (up_dn),
        .load     (load),
        .data_in  (data_in),
        .one_shot (one_shot),
        .count    (count),
        .tc       (tc),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]  id;
        logic [W-1:0] cnt;
        logic         tc;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   vec_id = 0;

    task automatic check(input string name, input logic [W-1:0] a_cnt, input logic a_tc,
                         input logic a_done, input logic [W-1:0] e_cnt, input logic e_tc,
                         input logic e_done);
        n_cmp++;
        if (a_cnt !== e_cnt || a_tc !== e_tc || a_done !== e_done) begin
            n_err++;
            $display("FAIL %s: got count=%0d tc=%0b done=%0b, expected count=%0d tc=%0b done=%0b",
                     name, a_cnt, a_tc, a_done, e_cnt, e_tc, e_done);
        end
    endtask

    // Present inputs for the next rising edge and queue the expected post-edge outputs.
    task automatic drive(input logic en, input logic ud, input logic ld, input logic [W-1:0] din,
                         input logic os, input logic [W-1:0] e_cnt, input logic e_tc,
                         input logic e_done);
        exp_t e;
        @(negedge clk);
        enable   = en;
        up_dn    = ud;
        load     = ld;
        data_in  = din;
        one_shot = os;
        e.id   = 16'(vec_id);
        e.cnt  = e_cnt;
        e.tc   = e_tc;
        e.done = e_done;
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic idle_inputs();
        enable   = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        one_shot = 1'b0;
    endtask

    // Monitor: after every rising edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("vec%0d", e.id), count, tc, done, e.cnt, e.tc, e.done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset_state", count, tc, done, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Async reset mid-count
        drive(0, 1, 1, 4'd7, 0, 4'd7, 0, 0);
        @(posedge clk);
        #3;
        idle_inputs();
        rst = 1'b0;
        #1;
        check("async_reset", count, tc, done, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 0, 4'd0, 0, 4'd1, 0, 0);

        // Up wrap from 0: tc only with the wrapped 0
        drive(0, 1, 1, 4'd0, 0, 4'd0, 0, 0);
        for (int i = 1; i <= 9; i++) drive(1, 1, 0, 4'd0, 0, 4'(i), 0, 0);
        drive(1, 1, 0, 4'd0, 0, 4'd0, 1, 0);
        drive(0, 1, 0, 4'd0, 0, 4'd0, 0, 0);

        // Down wrap after load 3, then hold with enable low
        drive(0, 1, 1, 4'd3, 0, 4'd3, 0, 0);
        drive(1, 0, 0, 4'd0, 0, 4'd2, 0, 0);
        drive(1, 0, 0, 4'd0, 0, 4'd1, 0, 0);
        drive(1, 0, 0, 4'd0, 0, 4'd0, 0, 0);
        drive(1, 0, 0, 4'd0, 0, 4'd9, 1, 0);
        drive(0, 0, 0, 4'd0, 0, 4'd9, 0, 0);
        drive(0, 0, 0, 4'd0, 0, 4'd9, 0, 0);

        // Load clamp and load-over-step priority at terminal count
        drive(1, 1, 1, 4'd15, 0, 4'd9, 0, 0);
        drive(1, 1, 0, 4'd0, 0, 4'd0, 1, 0);
        // Direction change takes effect the same edge: 0 is terminal going down
        drive(1, 0, 0, 4'd0, 0, 4'd9, 1, 0);

`ifdef MOD_COUNTER_ONE_SHOT_EN
        // One-shot halt, frozen in HALT, exit only by load
        drive(0, 1, 1, 4'd7, 1, 4'd7, 0, 0);
        drive(1, 1, 0, 4'd0, 1, 4'd8, 0, 0);
        drive(1, 1, 0, 4'd0, 1, 4'd9, 0, 0);
        drive(1, 1, 0, 4'd0, 1, 4'd9, 1, 1);
        drive(1, 1, 0, 4'd0, 1, 4'd9, 0, 1);
        drive(1, 0, 0, 4'd0, 0, 4'd9, 0, 1);
        drive(0, 1, 1, 4'd2, 1, 4'd2, 0, 0);
        drive(1, 1, 0, 4'd0, 1, 4'd3, 0, 0);
`else
        // one_shot ignored: always wraps, done stays 0
        drive(0, 1, 1, 4'd8, 1, 4'd8, 0, 0);
        drive(1, 1, 0, 4'd0, 1, 4'd9, 0, 0);
        drive(1, 1, 0, 4'd0, 1, 4'd0, 1, 0);
        drive(1, 1, 0, 4'd0, 1, 4'd1, 0, 0);
`endif

        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mod_counter_part_rtl.md
# mod_counter_part_rtl

Parametrised modulo-N up/down counter built as a control unit plus datapath unit. It adds a synchronous load, direction control, a terminal-count pulse and an optional one-shot mode to the team's basic binary counter. It serves as the general event/interval counter for timers and sequencers in the design: it runs freely and wraps, or in one-shot mode halts at its terminal value until it is reloaded.

## Interface
Parameters:
- size, 4: counter width in bits.
- MODULUS, 16: count range is 0..MODULUS-1. Legal values are 2 ≤ MODULUS ≤ 2**size.

Ports:
- clk  input  1  clock. All state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- enable  input  1  step enable, one step per enabled edge.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load of data_in.
- data_in  input  size  load value.
- one_shot  input  1  mode select: 1 = halt at terminal value, 0 = wrap.
- count  output  size  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- done  output  1  one-shot complete, registered level.

## Operation
- Terminal value T depends on direction: T = MODULUS-1 when up_dn=1, T = 0 when up_dn=0.
- Control unit FSM states:
  - RUN: the datapath may step.
  - HALT: count is frozen and done=1.
- Priority per edge: rst, then load, then enable step. When load=1 the enable input is ignored that cycle.
- Load:
  - count <= min(data_in, MODULUS-1).
  - FSM -> RUN, done <= 0, tc <= 0.
  - Load is legal in either state.
- Enabled step in RUN, count ≠ T: count moves ±1 with no wrap.
- Enabled step in RUN, count = T, one_shot=0: count wraps to 0 (up) or to MODULUS-1 (down), and tc <= 1.
- Enabled step in RUN, count = T, one_shot=1: count holds at T, FSM -> HALT, done <= 1, tc <= 1.
- HALT:
  - enable and up_dn have no effect.
  - Exit only through load or rst.
  - Deasserting one_shot in HALT does not exit HALT.
- tc is 0 on every edge that is not a terminal step.
- up_dn and one_shot are sampled on every edge. A direction change takes effect on the same edge, and T is recomputed from the sampled up_dn.
- Arithmetic is modulo MODULUS. count never exceeds MODULUS-1.

## Timing
- Reset values: count=0, tc=0, done=0, FSM=RUN. These take effect immediately on rst falling, with no clock edge needed.
- rst release: the first edge after rst rises may load or step.
- Latency:
  - count, tc and done all update on the same edge that samples the inputs, so they are visible one cycle after the inputs are presented.
  - In free-run, tc is high in the same cycle count shows the wrapped value.
- tc width is exactly one cycle per terminal event.
- With enable held high at a terminal count, consecutive wraps produce isolated pulses every MODULUS cycles.
- Reset asserted mid-count or in HALT aborts immediately. Outputs return to their reset values.
- Simultaneous load and terminal step: load wins, and tc stays 0.

## Configuration
- Macro: MOD_COUNTER_ONE_SHOT_EN.
- Defined: HALT state and one-shot behaviour are implemented as described above.
- Undefined:
  - The one_shot port is present but ignored.
  - The FSM is fixed in RUN, done is tied to 0, and the counter always wraps.
  - tc behaves as in free-run.

## Test plan
All scenarios use size=4, MODULUS=10.
- Async reset: count at 7, drive rst=0 between clock edges -> count=0, tc=0, done=0 before the next edge. Release rst, enable=1, up -> count 1 after the first edge.
- Up wrap: from 0, enable=1, up_dn=1, 10 edges -> count 1,2,…,9,0. tc=1 only in the cycle count=0, and 0 everywhere else.
- Down wrap and load: load data_in=3, then up_dn=0 with enable=1 -> count 2,1,0,9. tc=1 only with count=9. Holding enable=0 keeps count at 9.
- One-shot (macro defined): one_shot=1, load 7, up, enable=1 -> count 8,9,9,9. The third edge sets done=1 and gives a single-cycle tc. Later enables change nothing. Load 2 -> count=2, done=0, and counting resumes at 3.
- Load clamp and priority: load=1, data_in=15, enable=1 on the same edge -> count=9 with no step and tc=0. Next enabled up edge -> count=0, tc=1.
- Macro undefined: one_shot=1, load 8, up, enable=1 -> count 9,0,1. done stays 0 and tc pulses with count=0.
